mod_pll_supervisor: RTL and testbench
=====================================

# mod_pll_supervisor

PLL supervisor that sits on the control side of the iCE40 PLL wrapper: it drives the PLL's RESETB input and reads back its LOCK output. It sequences PLL reset and waits for lock. It requires lock to remain stable before releasing a system reset, retries on lock timeout, and declares a sticky fault after repeated failures. It runs on the 12 MHz board reference clock, so it never depends on the clock it supervises.

## Interface
Parameters:
- PLL_RST_CYCLES, 12: cycles o_pll_resetb is held low per PLL reset attempt (≥1).
- LOCK_TIMEOUT, 4800: cycles allowed in WAIT_LOCK before an attempt fails (400 µs at 12 MHz).
- STABLE_CYCLES, 1200: consecutive synchronized-lock-high cycles required before release (≥1).
- MAX_RETRIES, 3: failed attempts that cause FAULT (1..15).

Ports:
- i_clk  in  1  12 MHz reference clock; the only clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_pll_locked  in  1  PLL LOCK; asynchronous to i_clk.
- o_pll_resetb  out  1  to PLL RESETB; 0 holds the PLL in reset.
- o_rst_n  out  1  system reset, active-low; downstream domains re-synchronize it.
- o_ready  out  1  high only in RUN.
- o_fault  out  1  sticky; high only in FAULT.
- o_retry_cnt  out  4  failed lock attempts since reset.
- o_loss_cnt  out  8  lock-loss events in RUN; saturates at 255.

## Operation
- i_pll_locked passes through a 2-flop synchronizer. All decisions use the synchronized value `lk`.
- Every output is registered. Reset values: state PLL_RST, counter 0, o_pll_resetb 0, o_rst_n 0, o_ready 0, o_fault 0, o_retry_cnt 0, o_loss_cnt 0, synchronizer flops 0.
- One shared counter, `cnt`, is sized with $clog2 of the largest of the three cycle parameters. It is cleared on every state change.
- PLL_RST:
  - Drives o_pll_resetb 0 and ignores `lk`.
  - When `cnt` = PLL_RST_CYCLES-1, moves to WAIT_LOCK and drives o_pll_resetb 1 on the same edge.
- WAIT_LOCK:
  - If `lk` = 1, moves to STABLE.
  - Otherwise, when `cnt` = LOCK_TIMEOUT-1, the attempt fails and o_retry_cnt increments. If the new count equals MAX_RETRIES, moves to FAULT; otherwise moves to PLL_RST.
  - If lock and timeout occur in the same cycle, lock wins.
- STABLE:
  - If `lk` = 0, returns to WAIT_LOCK with the timeout restarted and no retry counted.
  - When `cnt` = STABLE_CYCLES-1 with `lk` = 1, moves to RUN and sets o_rst_n and o_ready to 1 on that edge.
- RUN:
  - If `lk` = 0, clears o_rst_n and o_ready on the next edge, increments o_loss_cnt (saturating), and moves to PLL_RST.
  - o_retry_cnt is not cleared by leaving RUN.
- FAULT:
  - Terminal state: o_pll_resetb 0, o_rst_n 0, o_ready 0, o_fault 1.
  - Exits only via i_rst_n.
- Asserting i_rst_n at any point, including mid-sequence, returns all state to reset values immediately. The sequence restarts from PLL_RST.

## Timing
- Let edge k be the first rising edge at which the synchronizer samples i_pll_locked high.
  - STABLE is entered at edge k+2.
  - o_rst_n rises at edge k+STABLE_CYCLES+2, provided lock stays high.
- Let edge m be the first edge sampling i_pll_locked low while in RUN. o_rst_n falls at edge m+2.
- After i_rst_n deasserts, o_pll_resetb stays low for exactly PLL_RST_CYCLES rising edges.
- An attempt that fails with no lock takes PLL_RST_CYCLES + LOCK_TIMEOUT cycles.
- Lock pulses shorter than one i_clk period may be missed. No requirement applies to such pulses.

## Structure
- Package `pkg_pll_sup` holds:
  - the state enum `pll_sup_state_t` (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT);
  - default parameter constants;
  - the o_loss_cnt saturation constant.
- Sub-module `mod_sync2` is a generic 2-flop synchronizer with async active-low reset and reset value 0. It is reused by other clock-domain crossings.
- The supervisor itself is one FSM plus the shared counter, the retry counter and the loss counter.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRIES=3.
- Clean lock: release reset, raise i_pll_locked 2 cycles after o_pll_resetb rises -> o_pll_resetb low for exactly 4 cycles; o_rst_n and o_ready rise exactly 10 edges after lock is first sampled; o_retry_cnt stays 0.
- Glitch during STABLE: lock high for 5 cycles, low for 1, then high -> no release at the original time; o_rst_n rises 10 edges after the second rise; o_retry_cnt stays 0.
- Timeout then success: no lock on attempt 1 -> after 20 cycles o_retry_cnt=1 and o_pll_resetb pulses low for 4 cycles; lock on attempt 2 -> RUN reached with o_retry_cnt=1.
- Fault: lock never asserted -> after 3×20=60 cycles o_fault=1, o_retry_cnt=3, o_pll_resetb=0; raising lock afterwards changes nothing; i_rst_n pulse clears everything.
- Loss in RUN: drop i_pll_locked -> o_rst_n low 2 edges later, o_loss_cnt=1, new 4-cycle PLL reset; 256 forced losses -> o_loss_cnt holds at 255.
- Reset mid-STABLE: assert i_rst_n during STABLE -> all outputs at reset values in the same cycle; the sequence restarts at PLL_RST after release.

Source files
------------

// File: rtl/pkg_pll_sup.sv
// Shared types and defaults for the PLL supervisor: state encoding, default
// parameter values and the loss-counter saturation point.
package pkg_pll_sup;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_sup_state_t;

    localparam int unsigned DEF_PLL_RST_CYCLES = 12;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 4800;
    localparam int unsigned DEF_STABLE_CYCLES  = 1200;
    localparam int unsigned DEF_MAX_RETRIES    = 3;

    localparam int unsigned LOSS_CNT_W   = 8;
    localparam logic [7:0]  LOSS_CNT_MAX = 8'd255;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mod_sync2.sv
// Generic two-flop synchronizer for single-bit (or independent multi-bit)
// asynchronous inputs; resets to 0.
module mod_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/mod_pll_supervisor.sv
// PLL supervisor: sequences PLL RESETB, waits for a stable lock, then releases
// the system reset; retries on timeout and latches a fault after MAX_RETRIES.
module mod_pll_supervisor
    import pkg_pll_sup::*;
#(
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pll_locked,
    output logic       o_pll_resetb,
    output logic       o_rst_n,
    output logic       o_ready,
    output logic       o_fault,
    output logic [3:0] o_retry_cnt,
    output logic [7:0] o_loss_cnt
);

    localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    pll_sup_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             pll_resetb_q, pll_resetb_d;
    logic             rst_n_q, rst_n_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             lk;

    mod_sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pll_locked),
        .o_q     (lk)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            pll_resetb_q <= 1'b0;
            rst_n_q      <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_resetb_q <= pll_resetb_d;
            rst_n_q      <= rst_n_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    // Next state, counters, and outputs decoded from the next state so they
    // change on the same edge as the state.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + 4'd1;
                    state_d = (retry_d == RETRY_LIMIT) ? FAULT : PLL_RST;
                end
            end
            STABLE: begin
                if (!lk)                        state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = RUN;
            end
            RUN: begin
                if (!lk) begin
                    state_d = PLL_RST;
                    if (loss_q != LOSS_CNT_MAX) loss_d = loss_q + 8'd1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase

        // Shared counter restarts on every state change and idles where unused.
        if ((state_d != state_q) || (state_d == RUN) || (state_d == FAULT)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        pll_resetb_d = (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
        rst_n_d      = (state_d == RUN);
        ready_d      = (state_d == RUN);
        fault_d      = (state_d == FAULT);
    end

    assign o_pll_resetb = pll_resetb_q;
    assign o_rst_n      = rst_n_q;
    assign o_ready      = ready_q;
    assign o_fault      = fault_q;
    assign o_retry_cnt  = retry_q;
    assign o_loss_cnt   = loss_q;

endmodule

// File: tb/tb_mod_pll_supervisor.sv
// Directed self-checking bench for mod_pll_supervisor with small cycle
// parameters (4 / 16 / 8 / 3); outputs sampled on the falling edge.
module tb_mod_pll_supervisor;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_resetb;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;
    int not_ready = 0;

    mod_pll_supervisor #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (16),
        .STABLE_CYCLES  (8),
        .MAX_RETRIES    (3)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pll_locked (pll_locked),
        .o_pll_resetb (pll_resetb),
        .o_rst_n      (sys_rst_n),
        .o_ready      (ready),
        .o_fault      (fault),
        .o_retry_cnt  (retry_cnt),
        .o_loss_cnt   (loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing on the following falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_resetb"}, 8'(pll_resetb), 8'd0);
        check({tag, "_rst_n"},  8'(sys_rst_n),  8'd0);
        check({tag, "_ready"},  8'(ready),      8'd0);
        check({tag, "_fault"},  8'(fault),      8'd0);
        check({tag, "_retry"},  8'(retry_cnt),  8'd0);
        check({tag, "_loss"},   8'(loss_cnt),   8'd0);
    endtask

    // Drop lock while in RUN, let the 4-cycle PLL reset finish, relock, return to RUN.
    task automatic loss_and_relock();
        pll_locked = 1'b0;
        step(3);
        step(4);
        pll_locked = 1'b1;
        step(11);
        if (ready !== 1'b1) not_ready++;
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        step(3);
        check_reset_vals("por");

        // Clean lock
        rst_n = 1'b1;
        step(3);
        check("clean_resetb_low_e3", 8'(pll_resetb), 8'd0);
        step(1);
        check("clean_resetb_high_e4", 8'(pll_resetb), 8'd1);
        step(2);
        pll_locked = 1'b1;
        step(10);
        check("clean_rst_n_k9", 8'(sys_rst_n), 8'd0);
        check("clean_ready_k9", 8'(ready), 8'd0);
        step(1);
        check("clean_rst_n_k10", 8'(sys_rst_n), 8'd1);
        check("clean_ready_k10", 8'(ready), 8'd1);
        check("clean_retry", 8'(retry_cnt), 8'd0);

        // Loss in RUN
        pll_locked = 1'b0;
        step(2);
        check("loss_rst_n_m1", 8'(sys_rst_n), 8'd1);
        step(1);
        check("loss_rst_n_m2", 8'(sys_rst_n), 8'd0);
        check("loss_ready_m2", 8'(ready), 8'd0);
        check("loss_cnt_1", loss_cnt, 8'd1);
        check("loss_resetb_m2", 8'(pll_resetb), 8'd0);
        step(3);
        check("loss_resetb_m5", 8'(pll_resetb), 8'd0);
        step(1);
        check("loss_resetb_m6", 8'(pll_resetb), 8'd1);

        // Glitch during STABLE
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(5);
        check("glitch_no_release_orig", 8'(sys_rst_n), 8'd0);
        step(5);
        check("glitch_rst_n_k2p9", 8'(sys_rst_n), 8'd0);
        step(1);
        check("glitch_rst_n_k2p10", 8'(sys_rst_n), 8'd1);
        check("glitch_retry", 8'(retry_cnt), 8'd0);

        // Loss counter saturation
        for (int i = 0; i < 254; i++) loss_and_relock();
        check("sat_loss_255", loss_cnt, 8'd255);
        loss_and_relock();
        check("sat_loss_hold", loss_cnt, 8'd255);
        check("sat_relock_ready", 8'(not_ready), 8'd0);
        check("sat_retry", 8'(retry_cnt), 8'd0);

        // Timeout then success
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_in_run");
        pll_locked = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(19);
        check("to_retry_e19", 8'(retry_cnt), 8'd0);
        check("to_resetb_e19", 8'(pll_resetb), 8'd1);
        step(1);
        check("to_retry_e20", 8'(retry_cnt), 8'd1);
        check("to_resetb_e20", 8'(pll_resetb), 8'd0);
        step(3);
        check("to_resetb_e23", 8'(pll_resetb), 8'd0);
        step(1);
        check("to_resetb_e24", 8'(pll_resetb), 8'd1);
        pll_locked = 1'b1;
        step(10);
        check("to_rst_n_k9", 8'(sys_rst_n), 8'd0);
        step(1);
        check("to_rst_n_k10", 8'(sys_rst_n), 8'd1);
        check("to_retry_run", 8'(retry_cnt), 8'd1);

        // Reset mid-STABLE
        pll_locked = 1'b0;
        step(3);
        step(4);
        pll_locked = 1'b1;
        step(5);
        check("mid_stable_resetb", 8'(pll_resetb), 8'd1);
        check("mid_stable_rst_n", 8'(sys_rst_n), 8'd0);
        check("mid_stable_retry", 8'(retry_cnt), 8'd1);
        check("mid_stable_loss", loss_cnt, 8'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid_stable");
        pll_locked = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        check("restart_resetb_e3", 8'(pll_resetb), 8'd0);
        step(1);
        check("restart_resetb_e4", 8'(pll_resetb), 8'd1);

        // Fault after three failed attempts
        step(55);
        check("fault_e59_fault", 8'(fault), 8'd0);
        check("fault_e59_retry", 8'(retry_cnt), 8'd2);
        step(1);
        check("fault_e60_fault", 8'(fault), 8'd1);
        check("fault_e60_retry", 8'(retry_cnt), 8'd3);
        check("fault_e60_resetb", 8'(pll_resetb), 8'd0);
        check("fault_e60_rst_n", 8'(sys_rst_n), 8'd0);
        check("fault_e60_ready", 8'(ready), 8'd0);
        pll_locked = 1'b1;
        step(20);
        check("fault_sticky", 8'(fault), 8'd1);
        check("fault_sticky_retry", 8'(retry_cnt), 8'd3);
        check("fault_sticky_resetb", 8'(pll_resetb), 8'd0);
        check("fault_sticky_rst_n", 8'(sys_rst_n), 8'd0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_fault");
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        check("post_fault_fault", 8'(fault), 8'd0);
        check("post_fault_resetb", 8'(pll_resetb), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
